mxint_block_quantizer: RTL and testbench

- Streaming FP32-to-MXINT block quantizer and the successor of the single-value broadcast converter.
- Accepts up to BLOCK_SIZE FP32 values serially and computes a true shared scale, which is the maximum effective biased exponent of the block.
- Quantises each element with round-to-nearest-even to a parametrised signed element width.
- Emits the block as one parallel word. It sits between the FP32 operand stream and the MX ALU operand registers.

---
 rtl/mxint_block_quantizer.sv | 204 ++++++++++++++++++++
 tb/tb_mxint_block_quantizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mxint_block_quantizer.sv
// Streaming FP32 -> MXINT block quantizer.
// Collects up to BLOCK_SIZE binary32 values, tracks the largest effective
// biased exponent as the shared E8M0 scale, then converts every buffered slot
// (one per cycle) to a signed 1.(ELEM_WIDTH-2) fixed-point element with
// round-to-nearest-even and symmetric saturation, and presents the whole block
// as one parallel word.
//
// Handshake: an input element transfers on a rising edge where i_valid and
// o_ready are both high; o_ready is high only while filling. The output block
// transfers on a rising edge where o_valid and i_ready are both high; once
// o_valid rises, o_valid, o_scale, o_elements and o_count hold steady until
// that transfer, and o_ready returns high on the following cycle.
module mxint_block_quantizer #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    localparam int CW = $clog2(BLOCK_SIZE + 1),
    localparam int IW = $clog2(BLOCK_SIZE)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [31:0]                    i_float32,
    input  logic                           i_last,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [SCALE_WIDTH-1:0]         o_scale,
    output logic [BLOCK_SIZE*ELEM_WIDTH-1:0] o_elements,
    output logic [CW-1:0]                  o_count,
    output logic [1:0]                     o_dbg_state
);

    localparam int FRAC       = ELEM_WIDTH - 2;
    localparam int SHIFT_BASE = 23 - FRAC;
    localparam logic [24:0] MAX_MAG = 25'((1 << (ELEM_WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_FINISH  = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              emax_q, emax_d;
    logic                    nan_q, nan_d;
    logic [31:0]             buf_q [BLOCK_SIZE];
    logic [31:0]             buf_d [BLOCK_SIZE];
    logic [ELEM_WIDTH-1:0]   elem_q [BLOCK_SIZE];
    logic [ELEM_WIDTH-1:0]   elem_d [BLOCK_SIZE];
    logic [SCALE_WIDTH-1:0]  scale_q, scale_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;

    // Converter datapath signals for the slot selected by idx_q.
    logic [31:0]             c_cur;
    logic [7:0]              c_eff;
    logic [23:0]             c_sig;
    logic [7:0]              c_d;
    logic [8:0]              c_shift;
    logic [87:0]             c_shifted;
    logic [23:0]             c_int;
    logic                    c_guard;
    logic                    c_sticky;
    logic [24:0]             c_mag;
    logic [24:0]             c_neg;
    logic [ELEM_WIDTH-1:0]   conv_elem;

    // Incoming element exponent bookkeeping.
    logic [7:0]              in_eff;
    logic [7:0]              in_base;

    // Convert one slot: align to the shared scale, round half to even, saturate, apply sign.
    always_comb begin
        c_cur     = buf_q[idx_q];
        if (CW'(idx_q) >= cnt_q) begin
            c_cur = 32'd0;            // unwritten slots behave as +0
        end
        c_eff     = (c_cur[30:23] == 8'd0) ? 8'd1 : c_cur[30:23];
        c_sig     = {(c_cur[30:23] != 8'd0), c_cur[22:0]};
        c_d       = emax_q - c_eff;
        c_shift   = 9'(c_d) + 9'(SHIFT_BASE);
        c_shifted = {c_sig, 64'd0} >> c_shift;
        c_int     = c_shifted[87:64];
        c_guard   = c_shifted[63];
        c_sticky  = |c_shifted[62:0];
        c_mag     = {1'b0, c_int} + 25'(c_guard && (c_sticky || c_int[0]));
        if (c_d >= 8'd32) begin
            c_mag = 25'd0;            // everything lands in sticky, rounds to zero
        end
        if (c_mag > MAX_MAG) begin
            c_mag = MAX_MAG;
        end
        c_neg     = 25'd0 - c_mag;
        conv_elem = c_cur[31] ? c_neg[ELEM_WIDTH-1:0] : c_mag[ELEM_WIDTH-1:0];
        if (nan_q) begin
            conv_elem = '0;
        end
    end

    // Next-state and next-output logic for the FILL/CONVERT/FINISH/OUTPUT sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        emax_d  = emax_q;
        nan_d   = nan_q;
        buf_d   = buf_q;
        elem_d  = elem_q;
        scale_d = scale_q;
        count_d = count_q;
        ready_d = ready_q;
        valid_d = valid_q;
        in_eff  = (i_float32[30:23] == 8'd0) ? 8'd1 : i_float32[30:23];
        in_base = (cnt_q == '0) ? 8'd1 : emax_q;

        case (state_q)
            ST_FILL: begin
                if (i_valid && ready_q) begin
                    buf_d[cnt_q[IW-1:0]] = i_float32;
                    cnt_d  = cnt_q + 1'b1;
                    emax_d = (in_eff > in_base) ? in_eff : in_base;
                    nan_d  = ((cnt_q == '0) ? 1'b0 : nan_q) | (i_float32[30:23] == 8'hFF);
                    if ((cnt_q == CW'(BLOCK_SIZE - 1)) || i_last) begin
                        state_d = ST_CONVERT;
                        ready_d = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            ST_CONVERT: begin
                elem_d[idx_q] = conv_elem;
                if (idx_q == IW'(BLOCK_SIZE - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_FINISH: begin
                scale_d = nan_q ? SCALE_WIDTH'(8'hFF) : SCALE_WIDTH'(emax_q);
                count_d = cnt_q;
                valid_d = 1'b1;
                state_d = ST_OUTPUT;
            end
            default: begin
                if (i_ready) begin
                    state_d = ST_FILL;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // State and registered outputs; reset discards any partial block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            idx_q   <= '0;
            emax_q  <= 8'd1;
            nan_q   <= 1'b0;
            for (int k = 0; k < BLOCK_SIZE; k++) begin
                buf_q[k]  <= 32'd0;
                elem_q[k] <= '0;
            end
            scale_q <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            emax_q  <= emax_d;
            nan_q   <= nan_d;
            buf_q   <= buf_d;
            elem_q  <= elem_d;
            scale_q <= scale_d;
            count_q <= count_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < BLOCK_SIZE; g++) begin : g_pack
            assign o_elements[g*ELEM_WIDTH +: ELEM_WIDTH] = elem_q[g];
        end
    endgenerate

    assign o_ready     = ready_q;
    assign o_valid     = valid_q;
    assign o_scale     = scale_q;
    assign o_count     = count_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mxint_block_quantizer.sv
// Directed bench for mxint_block_quantizer (BLOCK_SIZE=32, ELEM_WIDTH=8).
module tb_mxint_block_quantizer;

    localparam int BS = 32;
    localparam int EW = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic             i_last = 1'b0;
    logic             i_ready = 1'b0;
    logic [31:0]      i_float32 = 32'd0;
    logic             o_ready;
    logic             o_valid;
    logic [7:0]       o_scale;
    logic [BS*EW-1:0] o_elements;
    logic [5:0]       o_count;
    logic [1:0]       o_dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int seen_cyc = 0;

    logic [31:0] vals [BS];
    logic [7:0]  exp_e [BS];

    mxint_block_quantizer #(.BLOCK_SIZE(BS), .ELEM_WIDTH(EW), .SCALE_WIDTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_float32   (i_float32),
        .i_last      (i_last),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_scale     (o_scale),
        .o_elements  (o_elements),
        .o_count     (o_count),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and edge counter.
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 0, 32'(o_ready), 32'd1);
        chk({tag, "_valid"}, 0, 32'(o_valid), 32'd0);
        chk({tag, "_scale"}, 0, 32'(o_scale), 32'd0);
        chk({tag, "_count"}, 0, 32'(o_count), 32'd0);
        checks++;
        assert (o_elements === '0) else begin
            errors++;
            $error("FAIL %s_elements observed=%h expected=0", tag, o_elements);
        end
    endtask

    task automatic set_all(input logic [31:0] v, input logic [7:0] e);
        for (int k = 0; k < BS; k++) begin
            vals[k]  = v;
            exp_e[k] = e;
        end
    endtask

    // Drive n consecutive elements; o_ready is high throughout FILL.
    task automatic send_block(input int n, input bit use_last);
        for (int k = 0; k < n; k++) begin
            i_valid   = 1'b1;
            i_float32 = vals[k];
            i_last    = use_last && (k == n - 1);
            @(posedge i_clk);
            #1;
        end
        acc_cyc = cyc;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) begin
                seen     = 1'b1;
                seen_cyc = cyc;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL o_valid_timeout observed=0 expected=1");
        end
    endtask

    task automatic check_block(input string tag, input logic [7:0] es, input int ec);
        chk({tag, "_scale"}, 0, 32'(o_scale), 32'(es));
        chk({tag, "_count"}, 0, 32'(o_count), 32'(ec));
        for (int k = 0; k < BS; k++) begin
            chk({tag, "_elem"}, k, 32'(o_elements[k*EW +: EW]), 32'(exp_e[k]));
        end
    endtask

    task automatic consume(input string tag);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        chk({tag, "_post_ready"}, 0, 32'(o_ready), 32'd1);
        chk({tag, "_post_valid"}, 0, 32'(o_valid), 32'd0);
    endtask

    initial begin
        // Reset state.
        #12;
        chk_reset_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk_reset_outputs("post_reset");

        // 32 x 1.0 with latency check and a 10-cycle downstream stall.
        set_all(32'h3F800000, 8'h40);
        send_block(BS, 1'b0);
        wait_valid();
        chk("latency", 0, 32'(seen_cyc - acc_cyc), 32'd33);
        check_block("ones", 8'h7F, 32);
        i_valid   = 1'b1;
        i_float32 = 32'h40800000;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            chk("stall_valid", k, 32'(o_valid), 32'd1);
            chk("stall_ready", k, 32'(o_ready), 32'd0);
            chk("stall_scale", k, 32'(o_scale), 32'h7F);
            chk("stall_count", k, 32'(o_count), 32'd32);
            chk("stall_elem31", k, 32'(o_elements[31*EW +: EW]), 32'h40);
        end
        i_valid = 1'b0;
        consume("ones");

        // 4.0 sets the scale; -1.0 in slot 5.
        set_all(32'h3F800000, 8'h10);
        vals[0] = 32'h40800000; exp_e[0] = 8'h40;
        vals[5] = 32'hBF800000; exp_e[5] = 8'hF0;
        send_block(BS, 1'b0);
        wait_valid();
        check_block("four", 8'h81, 32);
        consume("four");

        // Rounding and saturation at scale 0x7F.
        set_all(32'h3F800000, 8'h40);
        vals[0] = 32'h3FFF0000; exp_e[0] = 8'h7F;
        vals[1] = 32'h3FFE0000; exp_e[1] = 8'h7F;
        vals[2] = 32'h3FC10000; exp_e[2] = 8'h60;
        vals[3] = 32'hBFFF0000; exp_e[3] = 8'h81;
        send_block(BS, 1'b0);
        wait_valid();
        check_block("round", 8'h7F, 32);
        consume("round");

        // Short block of three: padded slots must read zero.
        set_all(32'h00000000, 8'h00);
        vals[0] = 32'h3F800000; exp_e[0] = 8'h20;
        vals[1] = 32'h40000000; exp_e[1] = 8'h40;
        vals[2] = 32'hBF800000; exp_e[2] = 8'hE0;
        send_block(3, 1'b1);
        wait_valid();
        check_block("short", 8'h80, 3);
        consume("short");

        // Underflow below a 2^20 element.
        set_all(32'h3F800000, 8'h00);
        vals[0] = 32'h49800000; exp_e[0] = 8'h40;
        send_block(BS, 1'b0);
        wait_valid();
        check_block("under", 8'h93, 32);
        consume("under");

        // NaN in a short block forces scale 0xFF and zero elements.
        set_all(32'h3F800000, 8'h00);
        vals[2] = 32'h7FC00000;
        send_block(4, 1'b1);
        wait_valid();
        check_block("nan", 8'hFF, 4);
        consume("nan");

        // Zeros and small subnormals: scale 0x01, all elements 0.
        set_all(32'h00000000, 8'h00);
        vals[1] = 32'h00000001;
        vals[2] = 32'h80000000;
        vals[3] = 32'h00001000;
        vals[4] = 32'h80000001;
        send_block(BS, 1'b0);
        wait_valid();
        check_block("zero", 8'h01, 32);
        consume("zero");

        // Leave a nonzero block on the outputs, then reset mid-FILL.
        set_all(32'h3F800000, 8'h40);
        send_block(BS, 1'b0);
        wait_valid();
        check_block("pre_rst", 8'h7F, 32);
        consume("pre_rst");
        set_all(32'h40000000, 8'h40);
        send_block(5, 1'b0);
        i_rst_n = 1'b0;
        #2;
        chk_reset_outputs("rst_fill");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        set_all(32'h3F800000, 8'h40);
        send_block(BS, 1'b0);
        wait_valid();
        check_block("after_rst_fill", 8'h7F, 32);
        consume("after_rst_fill");

        // Reset mid-CONVERT, then a full block with a different scale.
        set_all(32'h3F800000, 8'h40);
        send_block(BS, 1'b0);
        repeat (10) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #2;
        chk_reset_outputs("rst_conv");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        set_all(32'h3F800000, 8'h10);
        vals[0] = 32'h40800000; exp_e[0] = 8'h40;
        vals[5] = 32'hBF800000; exp_e[5] = 8'hF0;
        send_block(BS, 1'b0);
        wait_valid();
        check_block("after_rst_conv", 8'h81, 32);
        consume("after_rst_conv");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
